lsq_ctrl: RTL

LSQ_CTRL -- requirements
Module: lsq_ctrl

---
 rtl/lsq_pkg.sv | 54 +++++
 rtl/lsq_fifo.sv | 98 +++++++++
 rtl/lsq_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue controller: op and size codes,
// FSM state type, ROB tag width and small op-decoding helpers.
package lsq_pkg;

   localparam int ROB_W = 3;

   localparam logic [4:0] OP_LB  = 5'd0;
   localparam logic [4:0] OP_LH  = 5'd1;
   localparam logic [4:0] OP_LW  = 5'd2;
   localparam logic [4:0] OP_LBU = 5'd3;
   localparam logic [4:0] OP_LHU = 5'd4;
   localparam logic [4:0] OP_SB  = 5'd5;
   localparam logic [4:0] OP_SH  = 5'd6;
   localparam logic [4:0] OP_SW  = 5'd7;
   localparam logic [4:0] OP_NOP = 5'd31;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

   // Any code outside 0..7 behaves exactly like OP_NOP.
   function automatic logic op_is_valid(input logic [4:0] op);
      return op <= OP_SW;
   endfunction

   function automatic logic op_is_load(input logic [4:0] op);
      return op <= OP_LHU;
   endfunction

   function automatic logic op_is_store(input logic [4:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   function automatic logic [1:0] op_size(input logic [4:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
         OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
         default:              return SIZE_WORD;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [4:0] op, input logic [31:0] d);
      case (op)
         OP_LB:   return {{24{d[7]}}, d[7:0]};
         OP_LH:   return {{16{d[15]}}, d[15:0]};
         OP_LBU:  return {24'd0, d[7:0]};
         OP_LHU:  return {16'd0, d[15:0]};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/lsq_fifo.sv
// Circular buffer of queued memory ops with a per-entry committed flag that is
// set by tag match; flush empties the buffer in one edge.
module lsq_fifo
   import lsq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [4:0]       push_op,
   input  logic [31:0]      push_addr,
   input  logic [ROB_W-1:0] push_rob,
   input  logic [31:0]      push_data,
   input  logic             pop,
   input  logic             flush,
   input  logic             set_valid,
   input  logic [ROB_W-1:0] set_rob,
   output logic [4:0]       head_op,
   output logic [31:0]      head_addr,
   output logic [ROB_W-1:0] head_rob,
   output logic [31:0]      head_data,
   output logic             head_committed,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]    head_ptr_reg;
   logic [PW-1:0]    tail_ptr_reg;
   logic [PW:0]      count_reg;
   logic [DEPTH-1:0] committed_reg;
   logic [DEPTH-1:0] match_vec;
   logic [DEPTH-1:0] write_vec;
   logic             push_ok;
   logic             pop_ok;
   logic             push_commit;

   logic [4:0]       op_mem   [DEPTH];
   logic [31:0]      addr_mem [DEPTH];
   logic [ROB_W-1:0] rob_mem  [DEPTH];
   logic [31:0]      data_mem [DEPTH];

   assign full        = (count_reg == (PW+1)'(DEPTH));
   assign empty       = (count_reg == '0);
   assign push_ok     = push & ~full & ~flush;
   assign pop_ok      = pop & ~empty & ~flush;
   // A store enqueued on the same edge as its own commit arrives already committed.
   assign push_commit = set_valid & op_is_store(push_op) & (push_rob == set_rob);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [PW-1:0] offset;
         logic          live;
         assign offset        = PW'(gi) - head_ptr_reg;
         assign live          = ({1'b0, offset} < count_reg);
         assign match_vec[gi] = set_valid & live & op_is_store(op_mem[gi]) & (rob_mem[gi] == set_rob);
         assign write_vec[gi] = push_ok & (tail_ptr_reg == PW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_ptr_reg  <= '0;
         tail_ptr_reg  <= '0;
         count_reg     <= '0;
         committed_reg <= '0;
      end else if (flush) begin
         head_ptr_reg  <= '0;
         tail_ptr_reg  <= '0;
         count_reg     <= '0;
         committed_reg <= '0;
      end else begin
         if (push_ok) tail_ptr_reg <= tail_ptr_reg + 1'b1;
         if (pop_ok)  head_ptr_reg <= head_ptr_reg + 1'b1;
         count_reg     <= count_reg + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
         committed_reg <= ((committed_reg | match_vec) & ~write_vec)
                        | (write_vec & {DEPTH{push_commit}});
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         op_mem[tail_ptr_reg]   <= push_op;
         addr_mem[tail_ptr_reg] <= push_addr;
         rob_mem[tail_ptr_reg]  <= push_rob;
         data_mem[tail_ptr_reg] <= push_data;
      end
   end

   assign head_op        = op_mem[head_ptr_reg];
   assign head_addr      = addr_mem[head_ptr_reg];
   assign head_rob       = rob_mem[head_ptr_reg];
   assign head_data      = data_mem[head_ptr_reg];
   assign head_committed = committed_reg[head_ptr_reg];

endmodule

// File: rtl/lsq_ctrl.sv
// Load/store queue controller: issues the queue head to memory one access at a
// time, holds stores until committed, and returns extended load results.
module lsq_ctrl
   import lsq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pause,
   input  logic             flush,
   input  logic [4:0]       au_op,
   input  logic [31:0]      au_addr,
   input  logic [ROB_W-1:0] au_rob,
   input  logic [31:0]      au_data,
   output logic             full,
   input  logic             commit_valid,
   input  logic [ROB_W-1:0] commit_rob,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [1:0]       mem_size,
   input  logic             mem_ack,
   input  logic [31:0]      mem_rdata,
   output logic             ld_valid,
   output logic [ROB_W-1:0] ld_rob,
   output logic [31:0]      ld_data
);

   state_t           state_reg, state_next;
   logic [4:0]       head_op;
   logic [31:0]      head_addr;
   logic [ROB_W-1:0] head_rob;
   logic [31:0]      head_data;
   logic             head_committed;
   logic             empty;
   logic             enq, issue, done, pop;

   logic [4:0]       req_op_reg;
   logic [31:0]      req_addr_reg;
   logic [31:0]      req_wdata_reg;
   logic [ROB_W-1:0] req_rob_reg;
   logic             flushed_reg;
   logic             drop_reg;
   logic [ROB_W-1:0] ld_rob_reg;
   logic [31:0]      ld_data_reg;

   assign enq = op_is_valid(au_op) & ~pause & ~flush & ~full;
   // An access flushed while in flight has already left the queue; don't pop again.
   assign pop = done & ~flushed_reg;

   lsq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk            (clk),
      .rst            (rst),
      .push           (enq),
      .push_op        (au_op),
      .push_addr      (au_addr),
      .push_rob       (au_rob),
      .push_data      (au_data),
      .pop            (pop),
      .flush          (flush),
      .set_valid      (commit_valid),
      .set_rob        (commit_rob),
      .head_op        (head_op),
      .head_addr      (head_addr),
      .head_rob       (head_rob),
      .head_data      (head_data),
      .head_committed (head_committed),
      .full           (full),
      .empty          (empty)
   );

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      done       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!pause && !flush && !empty && (op_is_load(head_op) || head_committed)) begin
               state_next = ST_REQ;
               issue      = 1'b1;
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               done       = 1'b1;
               state_next = op_is_load(req_op_reg) ? ST_RESP : ST_IDLE;
            end
         end
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         req_op_reg    <= '0;
         req_addr_reg  <= '0;
         req_wdata_reg <= '0;
         req_rob_reg   <= '0;
         flushed_reg   <= 1'b0;
         drop_reg      <= 1'b0;
         ld_rob_reg    <= '0;
         ld_data_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (issue) begin
            req_op_reg    <= head_op;
            req_addr_reg  <= head_addr;
            req_wdata_reg <= head_data;
            req_rob_reg   <= head_rob;
            flushed_reg   <= 1'b0;
         end else if (state_reg == ST_REQ && flush) begin
            flushed_reg <= 1'b1;
         end
         if (done && op_is_load(req_op_reg)) begin
            ld_rob_reg  <= req_rob_reg;
            ld_data_reg <= load_extend(req_op_reg, mem_rdata);
            drop_reg    <= flushed_reg | flush;
         end
      end
   end

   assign mem_req   = (state_reg == ST_REQ);
   assign mem_we    = op_is_store(req_op_reg);
   assign mem_addr  = req_addr_reg;
   assign mem_wdata = req_wdata_reg;
   assign mem_size  = op_size(req_op_reg);
   assign ld_valid  = (state_reg == ST_RESP) & ~drop_reg;
   assign ld_rob    = ld_rob_reg;
   assign ld_data   = ld_data_reg;

endmodule
